// File: rtl/dec_counter_pkg.sv
// dec_counter_pkg: shared defaults and the next-count helper
// for the decade counter slice.
package dec_counter_pkg;

  localparam int DEC_WIDTH_DEFAULT   = 4;
  localparam int DEC_MODULUS_DEFAULT = 10;

  // Wrap-aware next count; out-of-range values recover to 0.
  function automatic logic [31:0] dec_next(
    input logic [31:0] cur,
    input logic [31:0] modulus
  );
    logic [32:0] inc;
    inc = {1'b0, cur} + 33'd1;
    if (cur >= modulus - 32'd1) begin
      dec_next = '0;
    end else begin
      dec_next = inc[31:0];
    end
  endfunction

endpackage

// File: rtl/dec_counter_next.sv
// dec_counter_next: combinational next-count logic
// (increment, wrap at MODULUS-1, illegal-state recovery).
module dec_counter_next
  import dec_counter_pkg::*;
#(
  parameter int WIDTH   = DEC_WIDTH_DEFAULT,
  parameter int MODULUS = DEC_MODULUS_DEFAULT
) (
  input  logic [WIDTH-1:0] cur_i,
  output logic [WIDTH-1:0] next_o
);

  localparam logic [WIDTH:0] LAST =
    (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] inc;
  logic           wrap;

  assign ext = {1'b0, cur_i};
  assign inc = ext + 1'b1;

  // Anything at or past the last legal state loads 0.
  always_comb begin
    wrap   = (ext >= LAST) || inc[WIDTH];
    next_o = inc[WIDTH-1:0];
    if (wrap) begin
      next_o = '0;
    end
  end

endmodule

// File: rtl/dec_counter.sv
// dec_counter: free-running mod-MODULUS counter, sync reset.
// Optional terminal count output: DEC_COUNTER_TC_EN.
module dec_counter
  import dec_counter_pkg::*;
#(
  parameter int WIDTH   = DEC_WIDTH_DEFAULT,
  parameter int MODULUS = DEC_MODULUS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
`ifdef DEC_COUNTER_TC_EN
  ,
  output logic             tc
`endif
);

  if ((MODULUS < 2) || ((2 ** WIDTH) < MODULUS)) begin : g_bad_cfg
    $error("dec_counter: illegal WIDTH/MODULUS");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] cur_w;

  assign cur_w = count_q;

  dec_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .cur_i  (cur_w),
    .next_o (count_d)
  );

  // Count register; reset has priority over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef DEC_COUNTER_TC_EN
  localparam logic [WIDTH-1:0] LAST_CNT =
    WIDTH'(MODULUS - 1);

  // Carry into the next decade while at the last state.
  always_comb begin
    tc = 1'b0;
    if (!reset && (count_q == LAST_CNT)) begin
      tc = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dec_counter.sv
// tb_dec_counter: directed checks of the decade counter,
// including reset priority, wrap and illegal-state recovery.
module tb_dec_counter;

  logic       clk;
  logic       reset;
  logic [3:0] count;
`ifdef DEC_COUNTER_TC_EN
  logic       tc;
`endif

  int vec;
  int errs;
  bit armed;

  dec_counter dut (
    .clk   (clk),
    .reset (reset),
    .count (count)
`ifdef DEC_COUNTER_TC_EN
    ,
    .tc    (tc)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tc(input string tag, input bit exp);
`ifdef DEC_COUNTER_TC_EN
    chk(tag, 32'(tc), 32'(exp));
`else
    if (exp) begin end
    if (tag.len() == 0) begin end
`endif
  endtask

  task automatic edge_chk(
    input string      tag,
    input logic [3:0] exp
  );
    @(posedge clk);
    @(negedge clk);
    chk(tag, 32'(count), 32'(exp));
  endtask

  // X watch on every change of count after the first reset.
  always @(count) begin
    if (armed) begin
      vec++;
      assert (!$isunknown(count)) else begin
        errs++;
        $error("FAIL xwatch: got %0h want known", count);
      end
    end
  end

  initial begin
    vec   = 0;
    errs  = 0;
    armed = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      edge_chk("rst_hold", 4'd0);
      armed = 1'b1;
      chk_tc("tc_rst_hold", 1'b0);
    end

    reset = 1'b0;
    chk_tc("tc_rel", 1'b0);
    for (int k = 1; k <= 25; k++) begin
      edge_chk("run", 4'(k % 10));
      chk("run_le9", 32'(count <= 4'd9), 32'd1);
      chk_tc("tc_run", (k % 10) == 9);
    end

    edge_chk("to6", 4'd6);
    reset = 1'b1;
    edge_chk("rst_at6", 4'd0);
    reset = 1'b0;
    edge_chk("after6", 4'd1);

    for (int k = 2; k <= 9; k++) begin
      edge_chk("climb", 4'(k));
    end
    chk_tc("tc_at9", 1'b1);
    reset = 1'b1;
    #1;
    chk_tc("tc_rst9", 1'b0);
    edge_chk("rst_at9", 4'd0);
    reset = 1'b0;
    edge_chk("post9_1", 4'd1);
    edge_chk("post9_2", 4'd2);
    edge_chk("post9_3", 4'd3);

    force dut.cur_w = 4'd12;
    edge_chk("illegal", 4'd0);
    release dut.cur_w;
    #1;
    chk("illegal_hold", 32'(count), 32'd0);
    edge_chk("recover1", 4'd1);
    edge_chk("recover2", 4'd2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
